// File: rtl/ssb_ctrl_pkg.sv
// Shared types, widths and saturating amplitude arithmetic for the SSB keying sequencer.
package ssb_ctrl_pkg;

    localparam int NBITS            = 24;
    localparam int FREQ_W           = NBITS - 6;
    localparam int AMP_W            = NBITS + 3;
    localparam int DIV_W_DEF        = 16;
    localparam int GUARD_CYCLES_DEF = 1024;
    localparam logic [AMP_W-1:0] AMP_MAX = 27'd32505856;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_GUARD     = 3'd5
    } ssb_state_t;

    // Computed one bit wider than the amplitude so a large step can never wrap.
    function automatic logic [AMP_W-1:0] sat_add(input logic [AMP_W-1:0] a,
                                                 input logic [AMP_W-1:0] b,
                                                 input logic [AMP_W-1:0] lim);
        logic [AMP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[AMP_W-1:0];
    endfunction

    function automatic logic [AMP_W-1:0] sat_sub(input logic [AMP_W-1:0] a,
                                                 input logic [AMP_W-1:0] b);
        logic [AMP_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[AMP_W] ? '0 : d[AMP_W-1:0];
    endfunction

endpackage

// File: rtl/ssb_ramp_tick.sv
// Ramp prescaler: fires tick_o on the clock where the count equals div_i, then restarts at 0.
module ssb_ramp_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;

    assign tick_o = (cnt_q == div_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ssb_tx_sequencer.sv
// PTT keying and amplitude envelope sequencer for the SSB PWM modulator.
// Optional keyed-time watchdog enabled by defining SSB_TX_TIMEOUT_EN.
module ssb_tx_sequencer
    import ssb_ctrl_pkg::*;
#(
    parameter int DIV_W        = DIV_W_DEF,
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ptt_req,
    input  logic [FREQ_W-1:0] ssb_freq_cfg,
    input  logic [AMP_W-1:0]  target_amp,
    input  logic [AMP_W-1:0]  ramp_step,
    input  logic [DIV_W-1:0]  ramp_div,
    input  logic [31:0]       timeout_limit,
    output logic [FREQ_W-1:0] ssb_freq,
    output logic [AMP_W-1:0]  amplitude,
    output logic              stdby,
    output logic              mod_rst,
    output logic              tx_on,
    output logic              busy,
    output logic              timeout_flag,
    output logic [2:0]        dbg_state
);

    localparam int GW = $clog2(GUARD_CYCLES) + 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    ssb_state_t        state_q, state_d;
    logic [AMP_W-1:0]  tgt_q, stp_q, amp_q, up_amp, dn_amp;
    logic [DIV_W-1:0]  div_q;
    logic [FREQ_W-1:0] freq_q;
    logic [GW-1:0]     guard_q;
    logic              stdby_q, mod_rst_q, tx_on_q, busy_q;
    logic              tick, to_hit, tflag_q;

    assign up_amp = sat_add(amp_q, stp_q, tgt_q);
    assign dn_amp = sat_sub(amp_q, stp_q);

    // Restarting the prescaler on every state change gives each ramp a full first tick period.
    ssb_ramp_tick #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_d != state_q),
        .div_i  (div_q),
        .tick_o (tick)
    );

`ifdef SSB_TX_TIMEOUT_EN
    logic [31:0] to_cnt_q;

    assign to_hit = (state_q == ST_RAMP_UP || state_q == ST_HOLD) &&
                    (timeout_limit != 32'd0) && (to_cnt_q == timeout_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            tflag_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                to_cnt_q <= '0;
            end else if (state_q == ST_RAMP_UP || state_q == ST_HOLD) begin
                to_cnt_q <= to_cnt_q + 32'd1;
            end
            if (to_hit) begin
                tflag_q <= 1'b1;
            end else if (state_q == ST_IDLE && !ptt_req) begin
                tflag_q <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_limit;
    assign to_hit  = 1'b0;
    assign tflag_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (ptt_req && !tflag_q) state_d = ST_ARM;
            ST_ARM:       state_d = ST_RAMP_UP;
            ST_RAMP_UP: begin
                if (!ptt_req || to_hit)          state_d = ST_RAMP_DOWN;
                else if (tick && up_amp == tgt_q) state_d = ST_HOLD;
            end
            ST_HOLD:      if (!ptt_req || to_hit) state_d = ST_RAMP_DOWN;
            ST_RAMP_DOWN: if (tick && dn_amp == '0) state_d = ST_GUARD;
            ST_GUARD:     if (guard_q == GUARD_LAST) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            freq_q    <= '0;
            tgt_q     <= '0;
            stp_q     <= '0;
            div_q     <= '0;
            amp_q     <= '0;
            guard_q   <= '0;
            stdby_q   <= 1'b1;
            mod_rst_q <= 1'b1;
            tx_on_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stdby_q   <= (state_d == ST_IDLE) || (state_d == ST_ARM) || (state_d == ST_GUARD);
            mod_rst_q <= (state_d == ST_IDLE);
            tx_on_q   <= (state_d == ST_HOLD);
            busy_q    <= (state_d != ST_IDLE);

            if (state_q == ST_IDLE && state_d == ST_ARM) begin
                freq_q <= ssb_freq_cfg;
                tgt_q  <= (target_amp > AMP_MAX) ? AMP_MAX : target_amp;
                stp_q  <= (ramp_step == '0) ? AMP_W'(1) : ramp_step;
                div_q  <= ramp_div;
            end

            case (state_q)
                ST_RAMP_UP:   if (tick && state_d != ST_RAMP_DOWN) amp_q <= up_amp;
                ST_HOLD:      amp_q <= amp_q;
                ST_RAMP_DOWN: if (tick) amp_q <= dn_amp;
                default:      amp_q <= '0;
            endcase

            if (state_q == ST_GUARD && state_d == ST_GUARD) begin
                guard_q <= guard_q + 1'b1;
            end else begin
                guard_q <= '0;
            end
        end
    end

    assign ssb_freq     = freq_q;
    assign amplitude    = amp_q;
    assign stdby        = stdby_q;
    assign mod_rst      = mod_rst_q;
    assign tx_on        = tx_on_q;
    assign busy         = busy_q;
    assign timeout_flag = tflag_q;
    assign dbg_state    = state_q;

endmodule
